// File: rtl/fp_regfile_fcc.sv
// FPU register bank (NREG x 32-bit FPRs) with the FP condition flag.
// Feeds the FP ALU operands and absorbs its result, compare flag and mtc1/mfc1 moves.
module fp_regfile_fcc #(
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int IW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_a_idx,
  input  logic [IW-1:0] rd_b_idx,
  input  logic          rd_dbl,
  output logic [63:0]   in1,
  output logic [63:0]   in2,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_dbl,
  input  logic [63:0]   wr_data,
  input  logic          cmp_en,
  input  logic          con_in,
  output logic          fcc,
  input  logic          mtc1_en,
  input  logic [IW-1:0] mtc1_idx,
  input  logic [31:0]   mtc1_data,
  input  logic [IW-1:0] mfc1_idx,
  output logic [31:0]   mfc1_data,
  output logic          align_err
);

  logic [31:0] f    [NREG];
  logic        we_v [NREG];
  logic [31:0] wd_v [NREG];
  logic [31:0] rv   [NREG];

  logic [IW-1:0] wr_even, wr_odd;
  logic [IW-1:0] a_even, a_odd, b_even, b_odd;
  logic          odd_access;

  assign wr_even = {wr_idx[IW-1:1], 1'b0};
  assign wr_odd  = {wr_idx[IW-1:1], 1'b1};
  assign a_even  = {rd_a_idx[IW-1:1], 1'b0};
  assign a_odd   = {rd_a_idx[IW-1:1], 1'b1};
  assign b_even  = {rd_b_idx[IW-1:1], 1'b0};
  assign b_odd   = {rd_b_idx[IW-1:1], 1'b1};

  // Per-register write decode; the FP ALU result takes priority over mtc1 on a shared target.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      we_v[i] = 1'b0;
      wd_v[i] = 32'h0;
      if (mtc1_en && (mtc1_idx == IW'(i))) begin
        we_v[i] = 1'b1;
        wd_v[i] = mtc1_data;
      end
      if (wr_en) begin
        if (wr_dbl) begin
          if (wr_even == IW'(i)) begin
            we_v[i] = 1'b1;
            wd_v[i] = wr_data[63:32];
          end else if (wr_odd == IW'(i)) begin
            we_v[i] = 1'b1;
            wd_v[i] = wr_data[31:0];
          end
        end else if (wr_idx == IW'(i)) begin
          we_v[i] = 1'b1;
          wd_v[i] = wr_data[63:32];
        end
      end
    end
  end

  // Read view per register: forwarded incoming data when enabled, gated so reset reads as 0.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rv[i] = f[i];
      if ((BYPASS != 0) && !reset && we_v[i])
        rv[i] = wd_v[i];
    end
  end

  always_comb begin
    in1 = {rv[rd_a_idx], 32'h0};
    in2 = {rv[rd_b_idx], 32'h0};
    if (rd_dbl) begin
      in1 = {rv[a_even], rv[a_odd]};
      in2 = {rv[b_even], rv[b_odd]};
    end
  end

  assign mfc1_data = rv[mfc1_idx];

  assign odd_access = (rd_dbl && (rd_a_idx[0] || rd_b_idx[0])) ||
                      (wr_en && wr_dbl && wr_idx[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        f[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (we_v[i])
          f[i] <= wd_v[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcc       <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (cmp_en)
        fcc <= con_in;
      if (odd_access)
        align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_regfile_fcc.sv
// Directed self-checking bench for fp_regfile_fcc: reads, writes, priority, bypass, fcc, alignment.
module tb_fp_regfile_fcc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_a_idx, rd_b_idx, wr_idx, mtc1_idx, mfc1_idx;
  logic        rd_dbl, wr_en, wr_dbl, cmp_en, con_in, mtc1_en;
  logic [63:0] wr_data, in1, in2;
  logic [31:0] mtc1_data, mfc1_data;
  logic        fcc, align_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_regfile_fcc dut (
    .clk(clk), .reset(reset),
    .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx), .rd_dbl(rd_dbl),
    .in1(in1), .in2(in2),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_dbl(wr_dbl), .wr_data(wr_data),
    .cmp_en(cmp_en), .con_in(con_in), .fcc(fcc),
    .mtc1_en(mtc1_en), .mtc1_idx(mtc1_idx), .mtc1_data(mtc1_data),
    .mfc1_idx(mfc1_idx), .mfc1_data(mfc1_data),
    .align_err(align_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_a_idx = 0; rd_b_idx = 0; rd_dbl = 0;
    wr_en = 0; wr_idx = 0; wr_dbl = 0; wr_data = 64'h0;
    cmp_en = 0; con_in = 0;
    mtc1_en = 0; mtc1_idx = 0; mtc1_data = 32'h0; mfc1_idx = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check("reset_in1", in1, 64'h0);
    check("reset_fcc", {63'h0, fcc}, 64'h0);
    check("reset_align", {63'h0, align_err}, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1. every register reads zero, single and (aligned) double
    for (int i = 0; i < 32; i++) begin
      rd_dbl = 0; rd_a_idx = 5'(i); rd_b_idx = 5'(31 - i);
      #1;
      check("zero_single_a", in1, 64'h0);
      check("zero_single_b", in2, 64'h0);
      if (i % 2 == 0) begin
        rd_dbl = 1; rd_b_idx = 5'(i ^ 2);
        #1;
        check("zero_double_a", in1, 64'h0);
        check("zero_double_b", in2, 64'h0);
      end
    end
    idle();
    tick();
    check("zero_align", {63'h0, align_err}, 64'h0);

    // 2. double write of pi to F4/F5
    wr_en = 1; wr_dbl = 1; wr_idx = 4; wr_data = 64'h400921FB_54442D18;
    tick();
    idle();
    rd_dbl = 1; rd_a_idx = 4;
    #1;
    check("dbl_read_4", in1, 64'h400921FB_54442D18);
    rd_dbl = 0; rd_a_idx = 5; mfc1_idx = 4;
    #1;
    check("single_read_5", in1, 64'h54442D18_00000000);
    check("mfc1_4", {32'h0, mfc1_data}, 64'h400921FB);

    // 3. same-cycle forwarding
    idle();
    wr_en = 1; wr_idx = 7; wr_data = 64'h3F800000_DEADBEEF; rd_b_idx = 7; mfc1_idx = 7;
    #1;
    check("bypass_in2", in2, 64'h3F800000_00000000);
    check("bypass_mfc1", {32'h0, mfc1_data}, 64'h3F800000);
    tick();
    idle();
    rd_b_idx = 7;
    #1;
    check("after_wr_7", in2, 64'h3F800000_00000000);
    wr_en = 1; wr_dbl = 1; wr_idx = 8; wr_data = 64'hAAAA5555_12345678; rd_a_idx = 9;
    mtc1_en = 1; mtc1_idx = 10; mtc1_data = 32'hCAFEF00D; mfc1_idx = 10; rd_b_idx = 10;
    #1;
    check("bypass_odd_lo", in1, 64'h12345678_00000000);
    check("bypass_mtc1_in2", in2, 64'hCAFEF00D_00000000);
    check("bypass_mtc1_mfc1", {32'h0, mfc1_data}, 64'hCAFEF00D);
    tick();
    idle();
    rd_dbl = 1; rd_a_idx = 8; rd_b_idx = 10;
    #1;
    check("dbl_read_8", in1, 64'hAAAA5555_12345678);
    check("dbl_read_10", in2, 64'hCAFEF00D_00000000);

    // 4. FP ALU write vs mtc1
    idle();
    wr_en = 1; wr_idx = 2; wr_data = 64'h11111111_99999999;
    mtc1_en = 1; mtc1_idx = 2; mtc1_data = 32'h22222222;
    tick();
    idle();
    mfc1_idx = 2;
    #1;
    check("prio_same_f2", {32'h0, mfc1_data}, 64'h11111111);
    wr_en = 1; wr_idx = 2; wr_data = 64'h11111111_99999999;
    mtc1_en = 1; mtc1_idx = 3; mtc1_data = 32'h22222222;
    tick();
    idle();
    rd_dbl = 1; rd_a_idx = 2;
    #1;
    check("prio_diff_f2f3", in1, 64'h11111111_22222222);

    // 5. fcc capture, hold, async reset
    idle();
    cmp_en = 1; con_in = 1; wr_en = 1; wr_idx = 12; wr_data = 64'h0BADBEEF_00000000;
    tick();
    idle();
    mfc1_idx = 12;
    #1;
    check("fcc_set", {63'h0, fcc}, 64'h1);
    check("fcc_with_wr", {32'h0, mfc1_data}, 64'h0BADBEEF);
    repeat (3) tick();
    check("fcc_hold", {63'h0, fcc}, 64'h1);
    check("align_clean", {63'h0, align_err}, 64'h0);
    wr_en = 1; wr_idx = 12; wr_data = 64'h77777777_00000000;
    rd_a_idx = 12;
    #2;
    reset = 1'b1;
    #1;
    check("rst_fcc", {63'h0, fcc}, 64'h0);
    check("rst_in1", in1, 64'h0);
    check("rst_mfc1", {32'h0, mfc1_data}, 64'h0);
    tick();
    idle();
    reset = 1'b0;
    rd_a_idx = 12; rd_b_idx = 7;
    #1;
    check("rst_f12", in1, 64'h0);
    check("rst_f7", in2, 64'h0);

    // 6. odd double access: force alignment and sticky error
    wr_en = 1; wr_dbl = 1; wr_idx = 2; wr_data = 64'hA0A0A0A0_B1B1B1B1;
    tick();
    idle();
    rd_dbl = 1; rd_a_idx = 3;
    #1;
    check("odd_rd_in1", in1, 64'hA0A0A0A0_B1B1B1B1);
    check("odd_rd_pre", {63'h0, align_err}, 64'h0);
    tick();
    check("odd_rd_err", {63'h0, align_err}, 64'h1);
    rd_a_idx = 2;
    repeat (3) tick();
    check("err_sticky", {63'h0, align_err}, 64'h1);
    reset = 1'b1;
    #1;
    check("err_reset", {63'h0, align_err}, 64'h0);
    tick();
    reset = 1'b0;
    idle();
    wr_en = 1; wr_dbl = 1; wr_idx = 5; wr_data = 64'hC3C3C3C3_D4D4D4D4;
    tick();
    idle();
    rd_dbl = 1; rd_a_idx = 4;
    #1;
    check("odd_wr_data", in1, 64'hC3C3C3C3_D4D4D4D4);
    check("odd_wr_err", {63'h0, align_err}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
